// File: rtl/prng_idx_sampler_pkg.sv
// rtl/prng_idx_sampler_pkg.sv - shared encodings and defaults for the index sampler
// Purpose: PRNG command encoding, sampler FSM state encoding, default index sizing.
// Ports: none (package).
package prng_idx_sampler_pkg;

    typedef enum logic [1:0] {
        PRNG_HALT = 2'd0,
        PRNG_TRIG = 2'd1,
        PRNG_SEED = 2'd2
    } prng_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_OUT   = 3'd5
    } state_e;

    localparam int DEF_IDX_W   = 13;
    localparam int DEF_IDX_MAX = 4899;

endpackage

// File: rtl/prng_idx_sampler_idx_dup_cmp.sv
// rtl/prng_idx_sampler_idx_dup_cmp.sv - parallel duplicate check of a candidate against stored entries
// Purpose: single-cycle compare of cand against entries[0..count-1].
// Ports:
//   entries : stored index array (only the first count slots are meaningful)
//   count   : number of valid entries
//   cand    : candidate index
//   hit     : cand equals some valid entry
module idx_dup_cmp #(
    parameter int IDX_NUM = 16,
    parameter int IDX_W   = 13,
    parameter int CNT_W   = 5
) (
    input  logic [IDX_W-1:0] entries [IDX_NUM],
    input  logic [CNT_W-1:0] count,
    input  logic [IDX_W-1:0] cand,
    output logic             hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < IDX_NUM; i++) begin
            // Slots at or above count hold stale data from earlier sets.
            if ((CNT_W'(i) < count) && (entries[i] == cand)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prng_idx_sampler.sv
// rtl/prng_idx_sampler.sv - draws IDX_NUM distinct in-range indices from an external PRNG
// Purpose: seeds/triggers a PRNG, rejects out-of-range or duplicate candidates,
//          then streams the accepted set out in insertion order.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   seed_load, seed       : load seed into the PRNG (IDLE only)
//   start                 : begin one index set (IDLE only)
//   prng_typ_sel          : PRNG command (halt/trigger/load seed)
//   prng_t_dat            : seed presented to the PRNG
//   prng_valid/prng_r_dat : candidate returned by the PRNG
//   idx_valid/idx_ready/idx_dat/idx_last : output index stream
//   busy                  : not in IDLE
//   done                  : one-cycle pulse after the last index transfers
module prng_idx_sampler
    import prng_idx_sampler_pkg::*;
#(
    parameter int IDX_NUM = 16,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int IDX_MAX = DEF_IDX_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    input  logic             start,
    output logic [1:0]       prng_typ_sel,
    output logic [31:0]      prng_t_dat,
    input  logic             prng_valid,
    input  logic [IDX_W-1:0] prng_r_dat,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx_dat,
    output logic             idx_last,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(IDX_NUM + 1);
    localparam int IW    = (IDX_NUM > 1) ? $clog2(IDX_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IDX_NUM - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] rptr_q,  rptr_d;
    logic [IDX_W-1:0] cand_q,  cand_d;
    logic [31:0]      seed_q,  seed_d;
    logic             done_q,  done_d;
    logic             entry_we;
    logic             dup_hit;
    logic [IDX_W-1:0] entry_q [IDX_NUM];

    idx_dup_cmp #(
        .IDX_NUM (IDX_NUM),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) u_dup_cmp (
        .entries (entry_q),
        .count   (count_q),
        .cand    (cand_q),
        .hit     (dup_hit)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rptr_d   = rptr_q;
        cand_d   = cand_q;
        seed_d   = seed_q;
        done_d   = 1'b0;
        entry_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // seed_load wins; a simultaneous start is dropped.
                if (seed_load) begin
                    seed_d  = seed;
                    state_d = ST_SEED;
                end else if (start) begin
                    count_d = '0;
                    rptr_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_SEED:  state_d = ST_IDLE;
            ST_REQ:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (prng_valid) begin
                    cand_d  = prng_r_dat;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((cand_q > IDX_W'(IDX_MAX)) || dup_hit) begin
                    state_d = ST_REQ;
                end else begin
                    entry_we = 1'b1;
                    count_d  = count_q + CNT_W'(1);
                    rptr_d   = '0;
                    state_d  = (count_q == LAST_IDX) ? ST_OUT : ST_REQ;
                end
            end
            ST_OUT: begin
                if (idx_ready) begin
                    if (rptr_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rptr_d = rptr_q + CNT_W'(1);
                    end
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        if (rst) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            rptr_d   = '0;
            cand_d   = '0;
            seed_d   = '0;
            done_d   = 1'b0;
            entry_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        count_q <= count_d;
        rptr_q  <= rptr_d;
        cand_q  <= cand_d;
        seed_q  <= seed_d;
        done_q  <= done_d;
    end

    // Entry storage is not reset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (entry_we) begin
            entry_q[count_q[IW-1:0]] <= cand_q;
        end
    end

    // Outputs are gated by rst so they read zero from the first reset cycle.
    always_comb begin
        prng_typ_sel = PRNG_HALT;
        prng_t_dat   = '0;
        idx_valid    = 1'b0;
        idx_dat      = '0;
        idx_last     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        if (!rst) begin
            busy = (state_q != ST_IDLE);
            done = done_q;
            case (state_q)
                ST_SEED: begin
                    prng_typ_sel = PRNG_SEED;
                    prng_t_dat   = seed_q;
                end
                ST_REQ:  prng_typ_sel = PRNG_TRIG;
                ST_OUT: begin
                    idx_valid = 1'b1;
                    idx_dat   = entry_q[rptr_q[IW-1:0]];
                    idx_last  = (rptr_q == LAST_IDX);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prng_idx_sampler.sv
// tb/tb_prng_idx_sampler.sv - self-checking bench for prng_idx_sampler
module tb_prng_idx_sampler;

    localparam int IDX_NUM = 2;
    localparam int IDX_W   = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             seed_load;
    logic [31:0]      seed;
    logic             start;
    logic [1:0]       prng_typ_sel;
    logic [31:0]      prng_t_dat;
    logic             prng_valid;
    logic [IDX_W-1:0] prng_r_dat;
    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx_dat;
    logic             idx_last;
    logic             busy;
    logic             done;

    prng_idx_sampler #(
        .IDX_NUM (IDX_NUM),
        .IDX_W   (IDX_W),
        .IDX_MAX (4899)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seed_load    (seed_load),
        .seed         (seed),
        .start        (start),
        .prng_typ_sel (prng_typ_sel),
        .prng_t_dat   (prng_t_dat),
        .prng_valid   (prng_valid),
        .prng_r_dat   (prng_r_dat),
        .idx_valid    (idx_valid),
        .idx_ready    (idx_ready),
        .idx_dat      (idx_dat),
        .idx_last     (idx_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] dat;
        logic             last;
    } exp_t;

    typedef struct {
        int               n;
        logic [IDX_W-1:0] v [5];
        logic [IDX_W-1:0] e0;
        logic [IDX_W-1:0] e1;
        int               trig;
    } vec_t;

    int               total = 0;
    int               bad   = 0;
    int               trig_cnt = 0;
    int               done_cnt = 0;
    logic [IDX_W-1:0] prng_q [$];
    exp_t             exp_q  [$];
    vec_t             vecs   [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // PRNG model: each observed trigger consumes one queued value and returns it
    // one WAIT cycle later; with an empty queue the trigger goes unanswered.
    initial begin
        logic [IDX_W-1:0] v;
        prng_valid = 1'b0;
        prng_r_dat = '0;
        forever begin
            @(negedge clk);
            if (prng_typ_sel == 2'd1 && !rst) begin
                trig_cnt++;
                if (prng_q.size() > 0) begin
                    v = prng_q.pop_front();
                    repeat (2) @(posedge clk);
                    #1;
                    prng_valid = 1'b1;
                    prng_r_dat = v;
                    @(posedge clk);
                    #1;
                    prng_valid = 1'b0;
                end
            end
        end
    end

    // Output monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (idx_valid && idx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(idx_dat), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("idx_dat", 32'(idx_dat), 32'(e.dat));
                    chk("idx_last", 32'(idx_last), 32'(e.last));
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic push_exp(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
        exp_t e;
        e.dat = a; e.last = 1'b0; exp_q.push_back(e);
        e.dat = b; e.last = 1'b1; exp_q.push_back(e);
    endtask

    task automatic run_to_done(input string name, input int exp_trig);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (done_cnt == 0) chk({name, "_timeout"}, 32'(cyc), 32'd0);
        repeat (3) @(negedge clk);
        chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({name, "_triggers"}, 32'(trig_cnt), 32'(exp_trig));
        chk({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b0; idx_ready = 1'b1;

        vecs[0].n = 3; vecs[0].v = '{13'd5, 13'd5, 13'd7, 13'd0, 13'd0};
        vecs[0].e0 = 13'd5; vecs[0].e1 = 13'd7; vecs[0].trig = 3;
        vecs[1].n = 4; vecs[1].v = '{13'd4900, 13'd8191, 13'd12, 13'd13, 13'd0};
        vecs[1].e0 = 13'd12; vecs[1].e1 = 13'd13; vecs[1].trig = 4;
        vecs[2].n = 2; vecs[2].v = '{13'd0, 13'd4899, 13'd0, 13'd0, 13'd0};
        vecs[2].e0 = 13'd0; vecs[2].e1 = 13'd4899; vecs[2].trig = 2;
        vecs[3].n = 5; vecs[3].v = '{13'd4899, 13'd4899, 13'd4900, 13'd4899, 13'd1};
        vecs[3].e0 = 13'd4899; vecs[3].e1 = 13'd1; vecs[3].trig = 5;

        // Reset held three cycles: everything reads zero.
        repeat (3) @(negedge clk);
        chk("rst_typ_sel", 32'(prng_typ_sel), 32'd0);
        chk("rst_t_dat", prng_t_dat, 32'd0);
        chk("rst_idx_valid", 32'(idx_valid), 32'd0);
        chk("rst_idx_last", 32'(idx_last), 32'd0);
        chk("rst_idx_dat", 32'(idx_dat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Seed load, with a simultaneous start that must be dropped.
        @(posedge clk); #1 seed = 32'h0000_0001; seed_load = 1'b1; start = 1'b1;
        @(posedge clk); #1 seed_load = 1'b0; start = 1'b0; seed = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("seed_typ_sel", 32'(prng_typ_sel), 32'd2);
        chk("seed_t_dat", prng_t_dat, 32'd1);
        chk("seed_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("seed_after_typ_sel", 32'(prng_typ_sel), 32'd0);
        chk("seed_after_t_dat", prng_t_dat, 32'd0);
        chk("seed_start_dropped", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("seed_no_trigger", 32'(trig_cnt), 32'd0);

        // Table-driven index sets.
        for (int k = 0; k < 4; k++) begin
            trig_cnt = 0; done_cnt = 0;
            for (int j = 0; j < vecs[k].n; j++) prng_q.push_back(vecs[k].v[j]);
            push_exp(vecs[k].e0, vecs[k].e1);
            pulse_start();
            run_to_done($sformatf("vec%0d", k), vecs[k].trig);
        end

        // Consumer stall of 10 cycles in OUT.
        trig_cnt = 0; done_cnt = 0;
        idx_ready = 1'b0;
        prng_q.push_back(13'd42); prng_q.push_back(13'd43);
        push_exp(13'd42, 13'd43);
        pulse_start();
        cyc = 0;
        while (!idx_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_reach_out", 32'(idx_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(idx_valid), 32'd1);
            chk("stall_dat", 32'(idx_dat), 32'd42);
            chk("stall_last", 32'(idx_last), 32'd0);
        end
        @(posedge clk); #1 idx_ready = 1'b1;
        run_to_done("stall", 2);

        // Reset while waiting on the PRNG, then a fresh set.
        trig_cnt = 0; done_cnt = 0;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_typ_sel", 32'(prng_typ_sel), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_typ_sel", 32'(prng_typ_sel), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        trig_cnt = 0; done_cnt = 0;
        prng_q.push_back(13'd77); prng_q.push_back(13'd78);
        push_exp(13'd77, 13'd78);
        pulse_start();
        run_to_done("after_rst", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
